peripheral_memory_arbiter: RTL and testbench

Shares the peripheral's single-port 32x256 memory between NUM_REQ independent requesters, such as the bus-master port and internal engines. Each requester issues single-beat read/write accesses over a valid/ready handshake. Arbitration is round-robin, with an optional bounded burst hold for the current owner. The block drives the memory's write_en/address/data_in pins and returns read data one cycle after the grant.

---
 rtl/peripheral_memory_arbiter.sv | 109 ++++++++++
 tb/tb_peripheral_memory_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// A grant can be held for up to BURST_MAX consecutive accesses by the same
// owner while others are waiting.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/write/addr/wdata   per-requester access requests (packed slices)
//   req_ready                    one-hot-or-zero grant, same cycle as request
//   rsp_valid, rsp_rdata         read response, one cycle after a read grant
//   mem_write_en/address/data_in memory control pins
//   mem_data_out                 memory read data (one-cycle read latency)
//   busy_out                     a grant was issued in the previous cycle
module peripheral_memory_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDRWIDTH = 8,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_rdata,
    output logic                           mem_write_en,
    output logic [ADDRWIDTH-1:0]           mem_address,
    output logic [DATAWIDTH-1:0]           mem_data_in,
    input  logic [DATAWIDTH-1:0]           mem_data_out,
    output logic                           busy_out
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

    logic [IDX_W-1:0]   last;
    logic [CNT_W-1:0]   cnt;
    logic               held;
    logic [NUM_REQ-1:0] rd_pend;

    logic               sel_any;
    logic               sel_hold;
    logic [IDX_W-1:0]   sel_idx;
    logic               gnt;
    int                 cand;

    // Grant selection: burst hold first, otherwise search last+1 .. last (wrapping).
    always_comb begin
        sel_any  = 1'b0;
        sel_hold = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        if (held && req_valid[last] && (cnt < CNT_W'(BURST_MAX))) begin
            sel_any  = 1'b1;
            sel_hold = 1'b1;
            sel_idx  = last;
        end else begin
            for (int i = 1; i <= int'(NUM_REQ); i++) begin
                cand = (int'(last) + i) % int'(NUM_REQ);
                if (!sel_any && req_valid[IDX_W'(cand)]) begin
                    sel_any = 1'b1;
                    sel_idx = IDX_W'(cand);
                end
            end
        end
    end

    // Grants are suppressed while reset is asserted.
    assign gnt = sel_any & reset_n;

    // Memory pins and ready are driven straight from the selection (zero-latency grant).
    always_comb begin
        req_ready    = '0;
        mem_write_en = 1'b0;
        mem_address  = '0;
        mem_data_in  = '0;
        if (gnt) begin
            req_ready    = NUM_REQ'(1) << sel_idx;
            mem_write_en = req_write[sel_idx];
            mem_address  = req_addr[32'(sel_idx)*ADDRWIDTH +: ADDRWIDTH];
            mem_data_in  = req_wdata[32'(sel_idx)*DATAWIDTH +: DATAWIDTH];
        end
    end

    // Arbitration state and pending-read tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last    <= IDX_W'(NUM_REQ - 1);
            cnt     <= '0;
            held    <= 1'b0;
            rd_pend <= '0;
        end else if (gnt) begin
            last    <= sel_idx;
            cnt     <= sel_hold ? CNT_W'(cnt + CNT_W'(1)) : CNT_W'(1);
            held    <= 1'b1;
            rd_pend <= req_write[sel_idx] ? '0 : (NUM_REQ'(1) << sel_idx);
        end else begin
            cnt     <= '0;
            held    <= 1'b0;
            rd_pend <= '0;
        end
    end

    assign rsp_valid = rd_pend;
    assign rsp_rdata = mem_data_out;
    assign busy_out  = held;

endmodule

// File: tb/tb_peripheral_memory_arbiter.sv
// Directed self-checking bench for peripheral_memory_arbiter: a BURST_MAX=4
// instance with a behavioural memory, plus a BURST_MAX=1 instance on the same
// request inputs for the pure round-robin order. Read responses are checked
// through an expected-response queue.
module tb_peripheral_memory_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [NR-1:0] who;
        logic [DW-1:0] data;
    } rsp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;

    logic [NR-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]    rsp_rdata, mem_data_in, mem_data_out;
    logic [AW-1:0]    mem_address;
    logic             mem_write_en, busy_out;

    logic [NR-1:0]    rr_ready, rr_rsp_valid;
    logic [DW-1:0]    rr_rsp_rdata, rr_data_in, rr_dout;
    logic [AW-1:0]    rr_address;
    logic             rr_we, rr_busy;

    logic [DW-1:0]    mem [0:255];
    rsp_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;

    assign rr_dout = 32'h0;

    always #5 clk = ~clk;

    peripheral_memory_arbiter #(.NUM_REQ(NR), .ADDRWIDTH(AW), .DATAWIDTH(DW), .BURST_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_write_en(mem_write_en), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .busy_out(busy_out)
    );

    peripheral_memory_arbiter #(.NUM_REQ(NR), .ADDRWIDTH(AW), .DATAWIDTH(DW), .BURST_MAX(1)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rr_ready), .rsp_valid(rr_rsp_valid), .rsp_rdata(rr_rsp_rdata),
        .mem_write_en(rr_we), .mem_address(rr_address), .mem_data_in(rr_data_in),
        .mem_data_out(rr_dout), .busy_out(rr_busy)
    );

    // Behavioural single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rsp(input string tag);
        rsp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(e.who));
            chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(e.data));
        end else begin
            chk({tag, "_rsp_none"}, 64'(rsp_valid), 64'(0));
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with all requests pending: nothing may be granted.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'(8'hF0 + i), 32'(i));
        sample();
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_rr_ready", 64'(rr_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_we", 64'(mem_write_en), 64'(0));
        chk("rst_addr", 64'(mem_address), 64'(0));
        chk("rst_din", 64'(mem_data_in), 64'(0));
        chk("rst_busy", 64'(busy_out), 64'(0));

        // All four valid from reset: RR instance 0,1,2,3,..; burst instance 0x4,1x4,..
        next_cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) next_cyc();
            sample();
            chk($sformatf("rr_grant_%0d", k), 64'(rr_ready), 64'(4'b0001 << (k % 4)));
            chk($sformatf("burst_grant_%0d", k), 64'(req_ready), 64'(4'b0001 << (k / 4)));
            chk($sformatf("burst_busy_%0d", k), 64'(busy_out), 64'(k > 0));
            chk($sformatf("burst_addr_%0d", k), 64'(mem_address), 64'(8'hF0 + (k / 4)));
            chk($sformatf("burst_we_%0d", k), 64'(mem_write_en), 64'(1));
            chk_rsp($sformatf("a%0d", k));
        end

        // Requesters 0 and 2 continuously valid.
        next_cyc();
        req_valid = 4'b0101;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) next_cyc();
            sample();
            chk($sformatf("b_burst_grant_%0d", k), 64'(req_ready),
                64'(((k / 4) % 2 == 1) ? 4'b0100 : 4'b0001));
            chk($sformatf("b_rr_grant_%0d", k), 64'(rr_ready),
                64'((k % 2 == 1) ? 4'b0100 : 4'b0001));
            chk($sformatf("b_cnt_le_max_%0d", k), 64'(dut.cnt <= 3'd4), 64'(1));
        end

        // Owner drop: 0 gets its second grant with 3 waiting, then drops.
        next_cyc();
        req_valid = 4'b1001;
        sample();
        chk("drop_hold0", 64'(req_ready), 64'(4'b0001));
        next_cyc();
        req_valid = 4'b1000;
        sample();
        chk("drop_cnt_before", 64'(dut.cnt), 64'(2));
        chk("drop_grant3", 64'(req_ready), 64'(4'b1000));
        next_cyc();
        sample();
        chk("drop_cnt_after", 64'(dut.cnt), 64'(1));
        chk("drop_hold3", 64'(req_ready), 64'(4'b1000));

        // Idle for five cycles with last=3.
        next_cyc();
        req_valid = 4'b0000;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) next_cyc();
            sample();
            chk($sformatf("idle_ready_%0d", j), 64'(req_ready), 64'(0));
            chk($sformatf("idle_we_%0d", j), 64'(mem_write_en), 64'(0));
            chk($sformatf("idle_addr_%0d", j), 64'(mem_address), 64'(0));
            chk($sformatf("idle_busy_%0d", j), 64'(busy_out), 64'(j == 0));
            chk_rsp($sformatf("idle%0d", j));
        end

        // Req 1 and 3 together: 1 wins; req 1 writes 0xDEADBEEF to 0x10 then reads it.
        next_cyc();
        set_req(1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        set_req(3, 1'b1, 1'b0, 8'h10, 32'h0);
        sample();
        chk("wrap_grant1", 64'(req_ready), 64'(4'b0010));
        chk("wr_we", 64'(mem_write_en), 64'(1));
        chk("wr_addr", 64'(mem_address), 64'(8'h10));
        chk("wr_din", 64'(mem_data_in), 64'(32'hDEADBEEF));
        chk("wrap_busy", 64'(busy_out), 64'(0));
        next_cyc();
        req_write[1] = 1'b0;
        sample();
        chk("rd1_grant", 64'(req_ready), 64'(4'b0010));
        chk("rd1_we", 64'(mem_write_en), 64'(0));
        chk("rd1_addr", 64'(mem_address), 64'(8'h10));
        chk_rsp("wr1");
        exp_q.push_back('{who: 4'b0010, data: 32'hDEADBEEF});
        next_cyc();
        req_valid = 4'b1000;
        sample();
        chk("rd3_grant", 64'(req_ready), 64'(4'b1000));
        chk_rsp("rd1");
        exp_q.push_back('{who: 4'b1000, data: 32'hDEADBEEF});
        next_cyc();
        req_valid = 4'b0000;
        sample();
        chk_rsp("rd3");

        // Reset in the cycle after a read grant drops the response.
        next_cyc();
        set_req(2, 1'b1, 1'b0, 8'h10, 32'h0);
        sample();
        chk("rr_rd2_grant", 64'(req_ready), 64'(4'b0100));
        chk_rsp("pre_rd2");
        exp_q.push_back('{who: 4'b0100, data: 32'hDEADBEEF});
        next_cyc();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        exp_q.delete();
        sample();
        chk("rst_mid_ready", 64'(req_ready), 64'(0));
        chk("rst_mid_we", 64'(mem_write_en), 64'(0));
        chk("rst_mid_addr", 64'(mem_address), 64'(0));
        chk("rst_mid_din", 64'(mem_data_in), 64'(0));
        chk("rst_mid_busy", 64'(busy_out), 64'(0));
        chk("rst_mid_rsp", 64'(rsp_valid), 64'(0));

        next_cyc();
        reset_n   = 1'b1;
        req_valid = 4'b1111;
        req_write = 4'b1111;
        sample();
        chk("post_rst_grant0", 64'(req_ready), 64'(4'b0001));
        chk("post_rst_rr_grant0", 64'(rr_ready), 64'(4'b0001));
        chk_rsp("post_rst");
        next_cyc();
        req_valid = 4'b0000;
        sample();
        chk_rsp("final");
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
